uart_tx: RTL and testbench

Serial transmit engine of the APB UART. Sits directly downstream of the register block: consumes the TX data word, frame configuration and start-TX strobe it drives, serialises one asynchronous UART frame per accepted start on `tx_o`, and returns a transmit-done status that the register block samples into its status register.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive engines:
//   - uart_tx_state_e : transmit FSM states
//   - DBITS_5..DBITS_8: data_bit_num encodings (00=5 .. 11=8 data bits)
//   - STOP_1/STOP_2   : stop_bit_num encodings
//   - PARITY_EVEN/ODD : parity_type encodings
//   - data_mask()     : keeps only the N valid data bits of a byte
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_tx_state_e;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   localparam logic STOP_1 = 1'b0;
   localparam logic STOP_2 = 1'b1;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // N = 5 + dbits, so the mask is 0xFF shifted right by (3 - dbits).
   function automatic logic [7:0] data_mask(input logic [1:0] dbits);
      return 8'hFF >> (2'd3 - dbits);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_end_o during the terminal-count cycle, wrapping to 0 on that edge.
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   clear_i   : forces the count to 0 (dominates enable)
//   enable_i  : advance the count
//   bit_end_o : one-cycle pulse, last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_end_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end_o = enable_i && !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serialises one asynchronous UART frame (start, N data bits LSB first,
// optional parity, 1 or 2 stops) per start accepted in IDLE. Everything
// about the frame is captured at acceptance; inputs are ignored mid-frame.
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   start_tx_i     : start request, acted on only in IDLE
//   tx_data_i      : transmit word, low N bits used
//   data_bit_num_i : 00=5, 01=6, 10=7, 11=8 data bits
//   stop_bit_num_i : 0=1 stop bit, 1=2 stop bits
//   parity_en_i    : insert a parity bit
//   parity_type_i  : 0=even, 1=odd
//   tx_o           : serial line, idle high
//   tx_busy_o      : frame in progress
//   tx_done_o      : sticky frame-complete flag, cleared by the next start
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_tx_i,
   input  logic [31:0] tx_data_i,
   input  logic [1:0]  data_bit_num_i,
   input  logic        stop_bit_num_i,
   input  logic        parity_en_i,
   input  logic        parity_type_i,
   output logic        tx_o,
   output logic        tx_busy_o,
   output logic        tx_done_o
);

   uart_tx_state_e state_q;
   logic [7:0]     shift_q;
   logic [2:0]     bit_idx_q;
   logic [2:0]     last_idx_q;
   logic           stop2_q;
   logic           par_en_q;
   logic           par_bit_q;
   logic           stop_cnt_q;
   logic           tx_q;
   logic           busy_q;
   logic           done_q;

   logic [7:0]     data_d;
   logic           par_bit_d;
   logic           bit_end;
   logic           unused_data_hi;

   // Upper word bits are architecturally don't-care.
   assign unused_data_hi = ^tx_data_i[31:8];

   assign data_d    = tx_data_i[7:0] & data_mask(data_bit_num_i);
   // Masked bits are zero, so XOR over all 8 equals XOR over the N data bits.
   assign par_bit_d = (^data_d) ^ (parity_type_i == PARITY_ODD);

   // Timer held at 0 in IDLE so the start bit gets a full period from acceptance.
   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (state_q == ST_IDLE),
      .enable_i  (busy_q),
      .bit_end_o (bit_end)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         last_idx_q <= '0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (start_tx_i) begin
                  shift_q    <= data_d;
                  // N-1 = 4 + dbits
                  last_idx_q <= {1'b1, data_bit_num_i};
                  stop2_q    <= (stop_bit_num_i == STOP_2);
                  par_en_q   <= parity_en_i;
                  par_bit_q  <= par_bit_d;
                  bit_idx_q  <= '0;
                  stop_cnt_q <= 1'b0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_idx_q == last_idx_q) begin
                     stop_cnt_q <= 1'b0;
                     if (par_en_q) begin
                        tx_q    <= par_bit_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= shift_q >> 1;
                     tx_q      <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx_q       <= 1'b1;
                  stop_cnt_q <= 1'b0;
                  state_q    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (stop2_q && !stop_cnt_q) begin
                     stop_cnt_q <= 1'b1;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_o      = tx_q;
   assign tx_busy_o = busy_q;
   assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with CLKS_PER_BIT=4. Expected line
// waveforms come from a frame model built from the UART framing rules.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB = 4;

   logic        clk;
   logic        reset_n;
   logic        start_tx;
   logic [31:0] tx_data;
   logic [1:0]  dbits;
   logic        stop_bit;
   logic        par_en;
   logic        par_type;
   logic        tx;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;
   bit exp_bits[$];

   uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start_tx_i     (start_tx),
      .tx_data_i      (tx_data),
      .data_bit_num_i (dbits),
      .stop_bit_num_i (stop_bit),
      .parity_en_i    (par_en),
      .parity_type_i  (par_type),
      .tx_o           (tx),
      .tx_busy_o      (busy),
      .tx_done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame model: list of line levels, one entry per bit period.
   task automatic build_exp(input logic [31:0] d, input logic [1:0] db,
                            input logic s2, input logic pe, input logic pt);
      int n;
      bit p;
      n = 5 + int'(db);
      p = pt;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         exp_bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pe) exp_bits.push_back(p);
      exp_bits.push_back(1'b1);
      if (s2) exp_bits.push_back(1'b1);
   endtask

   // Must be called at a negedge; returns at the negedge right after the
   // frame-complete edge. hold keeps start high; disturb perturbs inputs.
   task automatic run_frame(input logic [31:0] d, input logic [1:0] db,
                            input logic s2, input logic pe, input logic pt,
                            input bit hold, input bit disturb, input string name);
      int len;
      int errs0;
      errs0 = miscompares;
      build_exp(d, db, s2, pe, pt);
      len = exp_bits.size() * CPB;
      tx_data  = d;
      dbits    = db;
      stop_bit = s2;
      par_en   = pe;
      par_type = pt;
      start_tx = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start_tx = 1'b0;
      for (int k = 0; k < len; k++) begin
         vectors += 3;
         if (tx !== exp_bits[k / CPB]) begin
            miscompares++;
            $display("FAIL %s tx cycle %0d: got %b want %b", name, k, tx, exp_bits[k / CPB]);
         end
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
         end
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done cycle %0d: got %b want 0", name, k, done);
         end
         if (disturb && k == 10) begin
            start_tx = 1'b1;
            tx_data  = 32'hFFFF_FFFF;
            dbits    = 2'b00;
            par_en   = 1'b1;
            stop_bit = 1'b1;
         end
         if (disturb && k == 12) start_tx = 1'b0;
         @(negedge clk);
      end
      vectors += 3;
      if (tx !== 1'b1) begin
         miscompares++;
         $display("FAIL %s end tx: got %b want 1", name, tx);
      end
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end busy: got %b want 0 after %0d cycles", name, busy, len);
      end
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s end done: got %b want 1 after %0d cycles", name, done, len);
      end
      $display("frame %s data=%02h n=%0d par=%0d/%0d stop=%0d cycles=%0d errors=%0d",
               name, d[7:0], 5 + int'(db), pe, pt, 1 + int'(s2), len, miscompares - errs0);
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      start_tx = 1'b0;
      tx_data  = '0;
      dbits    = 2'b11;
      stop_bit = 1'b0;
      par_en   = 1'b0;
      par_type = 1'b0;
      repeat (3) @(negedge clk);
      vectors += 3;
      if (tx !== 1'b1) begin miscompares++; $display("FAIL reset tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle after reset: got tx=%b busy=%b done=%b want 1/0/0", tx, busy, done);
      end
      $display("reset checked");
   endtask

   task automatic test_fixed();
      run_frame(32'h0000_00A5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "8N1");
      repeat (2) @(negedge clk);
      run_frame(32'hFFFF_FF43, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "7E1");
      repeat (2) @(negedge clk);
      run_frame(32'h0000_0013, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "5O2");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_frame($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_ignored();
      run_frame(32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ignore");
      // No second frame must follow the mid-frame start pulse.
      for (int k = 0; k < 3 * CPB; k++) begin
         vectors++;
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore idle cycle %0d: got tx=%b busy=%b done=%b want 1/0/1",
                     k, tx, busy, done);
         end
         @(negedge clk);
      end
      // Next accepted start clears done (checked inside run_frame).
      run_frame(32'h0000_005C, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "after_ignore");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_frame($urandom, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_first");
      // start still high: second frame accepted on the very next edge,
      // so done is high for exactly one cycle.
      run_frame($urandom, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_second");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_mid_reset();
      tx_data  = 32'h0000_0000;
      dbits    = 2'b11;
      stop_bit = 1'b0;
      par_en   = 1'b0;
      par_type = 1'b0;
      start_tx = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_tx = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || tx !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset pre: got busy=%b tx=%b want 1/0", busy, tx);
      end
      reset_n = 1'b0;
      #1;
      vectors += 3;
      if (tx !== 1'b1) begin miscompares++; $display("FAIL midreset tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset busy: got %b want 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("FAIL midreset done: got %b want 0", done); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset release: got tx=%b busy=%b done=%b want 1/0/0", tx, busy, done);
      end
      $display("mid-frame reset checked");
      run_frame($urandom, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_fixed();
      test_random();
      test_ignored();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
